// File: rtl/serial_reduce_ctrl.sv
// Serial reduction controller: folds a latched vector through one selectable
// 2-input boolean operator, one bit per clock, with valid/ready on both sides.
module serial_reduce_ctrl #(
  parameter int COUNT_OF_BITS = 4,
  parameter int IDX_W         = $clog2(COUNT_OF_BITS) + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [COUNT_OF_BITS-1:0] bitvector,
  input  logic [2:0]               opcode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     reduce,
  output logic                     busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(COUNT_OF_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_START = (COUNT_OF_BITS > 1) ? IDX_ONE : '0;

  state_t                   state, state_nxt;
  logic [COUNT_OF_BITS-1:0] vec_q;
  logic [2:0]               opc_q;
  logic                     acc_q;
  logic [IDX_W-1:0]         idx_q;
  logic                     cur_bit;
  logic                     acc_nxt;
  logic                     accept;

  // a = current vector bit, b = accumulator
  function automatic logic apply_op(input logic [2:0] op, input logic a, input logic b);
    logic r;
    case (op)
      3'd0:    r = a & b;
      3'd1:    r = a | b;
      3'd2:    r = a ^ b;
      3'd3:    r = ~(a & b);
      3'd4:    r = ~(a | b);
      3'd5:    r = ~a | b;
      3'd6:    r = a | ~b;
      default: r = ~(a ^ b);
    endcase
    return r;
  endfunction

  // Bit select written as a compare loop so the index width need not match the vector
  always_comb begin
    cur_bit = 1'b0;
    for (int i = 0; i < COUNT_OF_BITS; i++) begin
      if (idx_q == IDX_W'(i)) cur_bit = vec_q[i];
    end
  end

  assign acc_nxt = apply_op(opc_q, cur_bit, acc_q);
  assign accept  = (state == ST_IDLE) && in_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (in_valid) state_nxt = (COUNT_OF_BITS > 1) ? ST_RUN : ST_DONE;
      ST_RUN:  if (idx_q == IDX_LAST) state_nxt = ST_DONE;
      ST_DONE: if (out_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == ST_IDLE);
    out_valid = (state == ST_DONE);
    busy      = (state == ST_RUN) || (state == ST_DONE);
  end

  assign reduce = acc_q;

  // idx saturates at the last bit so it never wraps past N-1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_q <= '0;
      opc_q <= '0;
      acc_q <= 1'b0;
      idx_q <= '0;
    end else if (accept) begin
      vec_q <= bitvector;
      opc_q <= opcode;
      acc_q <= bitvector[0];
      idx_q <= IDX_START;
    end else if (state == ST_RUN) begin
      acc_q <= acc_nxt;
      if (idx_q != IDX_LAST) idx_q <= idx_q + IDX_ONE;
    end
  end

  a_idx_range: assert property (@(posedge clk) disable iff (!rst_n) idx_q <= IDX_LAST);
  a_done_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> (out_valid && $stable(reduce)));
  a_exclusive: assert property (@(posedge clk) disable iff (!rst_n) !(in_ready && busy));

endmodule

// File: tb/tb_serial_reduce_ctrl.sv
// Bench for serial_reduce_ctrl: N=4 and N=1 instances, table vectors,
// hand-written corner sequences and random transactions against a truth-table model.
module tb_serial_reduce_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       iv4, rdy4, ov4, ordy4, red4, busy4;
  logic [3:0] bv4;
  logic [2:0] op4;
  logic       iv1, rdy1, ov1, ordy1, red1, busy1;
  logic [0:0] bv1;
  logic [2:0] op1;

  serial_reduce_ctrl #(.COUNT_OF_BITS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(rdy4), .bitvector(bv4),
    .opcode(op4), .out_valid(ov4), .out_ready(ordy4), .reduce(red4), .busy(busy4));

  serial_reduce_ctrl #(.COUNT_OF_BITS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(rdy1), .bitvector(bv1),
    .opcode(op1), .out_valid(ov1), .out_ready(ordy1), .reduce(red1), .busy(busy1));

  int n_checks = 0;
  int n_pass   = 0;

  // Operator truth tables, indexed by {a, b} with a = vector bit, b = accumulator
  logic [3:0] tt [8];

  typedef struct {
    string      nm;
    logic [2:0] op;
    logic [3:0] vec;
    logic       exp;
    int         hold;
    bit         press;
  } vec_t;

  vec_t tbl [9];

  task automatic check(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", nm, act, exp);
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  function automatic logic model(input logic [2:0] op, input logic [3:0] v, input int n);
    logic       acc;
    logic [3:0] s;
    logic [3:0] row;
    acc = v[0];
    row = tt[op];
    for (int i = 1; i < n; i++) begin
      s   = v >> i;
      acc = row[{s[0], acc}];
    end
    return acc;
  endfunction

  function automatic logic g_rdy(input bit sel);  return sel ? rdy1  : rdy4;  endfunction
  function automatic logic g_ov(input bit sel);   return sel ? ov1   : ov4;   endfunction
  function automatic logic g_red(input bit sel);  return sel ? red1  : red4;  endfunction
  function automatic logic g_busy(input bit sel); return sel ? busy1 : busy4; endfunction

  task automatic set_in(input bit sel, input logic v, input logic [2:0] op, input logic [3:0] vec);
    if (sel) begin iv1 = v; op1 = op; bv1 = vec[0]; end
    else     begin iv4 = v; op4 = op; bv4 = vec;    end
  endtask

  task automatic set_ordy(input bit sel, input logic r);
    if (sel) ordy1 = r;
    else     ordy4 = r;
  endtask

  // Starts and ends at a falling edge. hold=0 keeps out_ready high throughout.
  task automatic txn(input bit sel, input string nm, input logic [2:0] op, input logic [3:0] vec,
                     input logic exp, input int hold, input bit press);
    int n;
    int k;
    bit bad;
    n = sel ? 1 : 4;
    check({nm, "_in_ready"}, g_rdy(sel), 1'b1);
    set_ordy(sel, hold == 0);
    set_in(sel, 1'b1, op, vec);
    @(posedge clk);
    @(negedge clk);
    set_in(sel, 1'b0, 3'($urandom), 4'($urandom));
    k = 0;
    bad = 0;
    while (!g_ov(sel) && k < 20) begin
      if (g_busy(sel) !== 1'b1 || g_rdy(sel) !== 1'b0) bad = 1;
      @(negedge clk);
      k++;
    end
    check_int({nm, "_latency"}, k, n - 1);
    check({nm, "_run_flags_ok"}, bad, 1'b0);
    check({nm, "_reduce"}, g_red(sel), exp);
    if (hold > 0) begin
      bad = 0;
      if (press) set_in(sel, 1'b1, 3'd1, 4'b0000);
      for (int h = 0; h < hold; h++) begin
        if (g_ov(sel) !== 1'b1 || g_red(sel) !== exp || g_rdy(sel) !== 1'b0 || g_busy(sel) !== 1'b1)
          bad = 1;
        @(negedge clk);
      end
      check({nm, "_hold_stable"}, bad, 1'b0);
      set_ordy(sel, 1'b1);
    end
    @(negedge clk);
    check({nm, "_back_idle"}, (g_ov(sel) === 1'b0) && (g_rdy(sel) === 1'b1) && (g_busy(sel) === 1'b0), 1'b1);
    check({nm, "_reduce_kept"}, g_red(sel), exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] rop;
    logic [3:0] rvec;
    int         rhold;

    tt[0] = 4'b1000;  // AND
    tt[1] = 4'b1110;  // OR
    tt[2] = 4'b0110;  // XOR
    tt[3] = 4'b0111;  // NAND
    tt[4] = 4'b0001;  // NOR
    tt[5] = 4'b1011;  // IMP
    tt[6] = 4'b1101;  // CIMP
    tt[7] = 4'b1001;  // XNOR

    tbl[0] = '{"imp_0110",   3'd5, 4'b0110, 1'b1, 0, 1'b0};
    tbl[1] = '{"nor_0110",   3'd4, 4'b0110, 1'b1, 0, 1'b0};
    tbl[2] = '{"xor_0110",   3'd2, 4'b0110, 1'b0, 0, 1'b0};
    tbl[3] = '{"and_1111",   3'd0, 4'b1111, 1'b1, 2, 1'b0};
    tbl[4] = '{"or_bp",      3'd1, 4'b0001, 1'b1, 5, 1'b1};
    tbl[5] = '{"or_0000",    3'd1, 4'b0000, 1'b0, 0, 1'b0};
    tbl[6] = '{"nand_1111",  3'd3, 4'b1111, 1'b0, 1, 1'b0};
    tbl[7] = '{"cimp_0110",  3'd6, 4'b0110, 1'b0, 0, 1'b0};
    tbl[8] = '{"xnor_1010",  3'd7, 4'b1010, 1'b1, 0, 1'b0};

    rst_n = 1'b0;
    iv4 = 1'b0; bv4 = '0; op4 = '0; ordy4 = 1'b0;
    iv1 = 1'b0; bv1 = '0; op1 = '0; ordy1 = 1'b0;
    #1;
    check("rst4_in_ready",  rdy4,  1'b1);
    check("rst4_out_valid", ov4,   1'b0);
    check("rst4_reduce",    red4,  1'b0);
    check("rst4_busy",      busy4, 1'b0);
    check("rst1_in_ready",  rdy1,  1'b1);
    check("rst1_out_valid", ov1,   1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // The or_bp entry presents 4'b0000 during DONE; or_0000 is that vector's transaction
    for (int i = 0; i < 9; i++)
      txn(1'b0, tbl[i].nm, tbl[i].op, tbl[i].vec, tbl[i].exp, tbl[i].hold, tbl[i].press);

    // Abort a transaction one cycle after acceptance
    set_ordy(1'b0, 1'b0);
    set_in(1'b0, 1'b1, 3'd1, 4'b1111);
    @(posedge clk);
    @(negedge clk);
    set_in(1'b0, 1'b0, 3'd0, 4'b0000);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", ov4,   1'b0);
    check("abort_in_ready",  rdy4,  1'b1);
    check("abort_busy",      busy4, 1'b0);
    check("abort_reduce",    red4,  1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    txn(1'b0, "rst_xnor_0000", 3'd7, 4'b0000, 1'b1, 0, 1'b0);

    txn(1'b1, "n1_imp_1", 3'd5, 4'b0001, 1'b1, 0, 1'b0);
    txn(1'b1, "n1_imp_0", 3'd5, 4'b0000, 1'b0, 2, 1'b0);

    for (int i = 0; i < 40; i++) begin
      rop   = 3'($urandom);
      rvec  = 4'($urandom);
      rhold = $urandom_range(0, 2);
      txn(1'b0, "rand4", rop, rvec, model(rop, rvec, 4), rhold, 1'b0);
    end
    for (int i = 0; i < 20; i++) begin
      rop   = 3'($urandom);
      rvec  = 4'($urandom_range(0, 1));
      rhold = $urandom_range(0, 2);
      txn(1'b1, "rand1", rop, rvec, model(rop, rvec, 1), rhold, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
